mem_stage_ctrl: RTL

- Controls the memory stage that sits behind the EX/MEM pipeline register.
- Takes the latched memRead/memWrite/halt control bits and drives the data memory enable and write strobe for variable-latency memory.
- Stalls the front of the pipeline (PC, IF/ID, ID/EX, EX/MEM) and inserts a bubble into MEM/WB until the access completes.
- Latches halt and fatal memory errors as sticky states.

---
 rtl/mem_stage_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data memory request, stalls the front of the pipeline
// during variable-latency accesses, and latches halt/error. Optional: MEM_STALL_CNT_EN.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic memRead,
    input  logic memWrite,
    input  logic halt,
    input  logic memBusy,
    input  logic memDone,
    input  logic memErr,
    output logic memEnable,
    output logic memWr,
    output logic stall,
    output logic bubble,
    output logic haltOut,
    output logic err
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [15:0] stallCount
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHalt = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam logic [CNT_W:0] MaxWait = (CNT_W + 1)'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             access;
    logic             timeout;
    logic             mem_en;
    logic             stall_c;

    assign access  = memRead | memWrite;
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout = (cnt_inc >= MaxWait);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_en  = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    stall_c = 1'b1;
                    state_d = StHalt;
                end else if (access) begin
                    if (memBusy) begin
                        // Request not yet accepted; the busy cycles count toward the timeout.
                        stall_c = 1'b1;
                        if (timeout) begin
                            state_d = StErr;
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        mem_en = 1'b1;
                        if (memErr) begin
                            stall_c = 1'b1;
                            state_d = StErr;
                        end else if (memDone) begin
                            cnt_d = '0;
                        end else begin
                            stall_c = 1'b1;
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                mem_en = 1'b1;
                if (memErr) begin
                    stall_c = 1'b1;
                    state_d = StErr;
                end else if (memDone) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    stall_c = 1'b1;
                    if (timeout) begin
                        state_d = StErr;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            StHalt: stall_c = 1'b1;
            StErr:  stall_c = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs are gated so that nothing escapes while reset is held.
    assign memEnable = rst & mem_en;
    assign memWr     = memEnable & memWrite;
    assign stall     = rst & stall_c;
    assign bubble    = stall;
    assign haltOut   = (state_q == StHalt);
    assign err       = (state_q == StErr);

`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (state_q == StIdle || state_q == StWait)
                     && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stallCount = stall_cnt_q;
`endif

endmodule
